// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Segment bit order is a..g then dp, MSB first.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam int NDIG = 4;

  localparam logic [NDIG-1:0] SEL_ALL_OFF = 4'b1111;
  localparam logic [7:0]      SEG_OFF     = 8'h00;

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to 7-segment lookup; output bit 6 is segment a, bit 0 is g.
// The decimal point is merged by the caller.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  logic [7:0] pat;

  always_comb begin
    pat = SEG_OFF;
    unique case (hex_i)
      4'h0: pat = 8'hFC;
      4'h1: pat = 8'h60;
      4'h2: pat = 8'hDA;
      4'h3: pat = 8'hF2;
      4'h4: pat = 8'h66;
      4'h5: pat = 8'hB6;
      4'h6: pat = 8'hBE;
      4'h7: pat = 8'hE0;
      4'h8: pat = 8'hFE;
      4'h9: pat = 8'hF6;
      4'hA: pat = 8'hEE;
      4'hB: pat = 8'h3E;
      4'hC: pat = 8'h1A;
      4'hD: pat = 8'h7A;
      4'hE: pat = 8'h9E;
      4'hF: pat = 8'h8E;
    endcase
  end

  assign seg_o = pat[SEG_A:SEG_G];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner with blanking gaps
// and frame-aligned double buffering of the displayed value.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int ON_CYC    = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        lz_suppress,
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  signal,
  output logic [3:0]  selector
);

  localparam int MAXC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] shv_q, shv_d, actv_q, actv_d;
  logic [3:0]  shdp_q, shdp_d, actdp_q, actdp_d;
  logic        pend_q, pend_d;
  logic        tick_q, tick_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  sig_q, sig_d;
  logic        boundary;
  logic        lz_blank;
  logic [3:0]  nib;
  logic [6:0]  seg7;

  seg_hex_decode u_dec (
    .hex_i (nib),
    .seg_o (seg7)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shv_d    = shv_q;
    shdp_d   = shdp_q;
    actv_d   = actv_q;
    actdp_d  = actdp_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    boundary = 1'b0;
    if (!en) begin
      state_d = ST_BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
      actv_d  = shv_q;
      actdp_d = shdp_q;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == BL_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d  = ST_BLANK;
            cnt_d    = '0;
            idx_d    = idx_q + 2'd1;
            boundary = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
    if (boundary) begin
      actv_d  = shv_q;
      actdp_d = shdp_q;
      pend_d  = 1'b0;
      tick_d  = 1'b1;
    end
    // a same-cycle load wins over the commit clearing pending
    if (load) begin
      shv_d  = value;
      shdp_d = dp_mask;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    nib      = actv_d[{idx_d, 2'b00} +: 4];
    lz_blank = 1'b0;
    if (lz_suppress) begin
      unique case (idx_d)
        2'd1:    lz_blank = (actv_d[15:4] == 12'h000);
        2'd2:    lz_blank = (actv_d[15:8] == 8'h00);
        2'd3:    lz_blank = (actv_d[15:12] == 4'h0);
        default: lz_blank = 1'b0;
      endcase
    end
    sel_d = SEL_ALL_OFF;
    sig_d = SEG_OFF;
    if (state_d == ST_ON) begin
      sel_d = ~(4'b0001 << idx_d);
      sig_d = {seg7 & {7{~lz_blank}}, actdp_d[idx_d]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      shv_q   <= '0;
      shdp_q  <= '0;
      actv_q  <= '0;
      actdp_q <= '0;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
      sel_q   <= SEL_ALL_OFF;
      sig_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shv_q   <= shv_d;
      shdp_q  <= shdp_d;
      actv_q  <= actv_d;
      actdp_q <= actdp_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
      sig_q   <= sig_d;
    end
  end

  assign pending    = pend_q;
  assign frame_tick = tick_q;
  assign signal     = sig_q;
  assign selector   = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with ON_CYC=4, BLANK_CYC=2.
// Outputs are sampled on the falling clock edge.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_suppress;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  signal;
  logic [3:0]  selector;

  int n_assert = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(
    .ON_CYC    (4),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load        (load),
    .value       (value),
    .dp_mask     (dp_mask),
    .lz_suppress (lz_suppress),
    .pending     (pending),
    .frame_tick  (frame_tick),
    .signal      (signal),
    .selector    (selector)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Positioned at the first blank cycle of digit k; leaves at the next one.
  task automatic digit(input int k, input logic [7:0] s,
                       input bit tk, input bit ldl);
    logic [3:0] es;
    for (int c = 0; c < 6; c++) begin
      es = 4'b0001 << k;
      es = ~es;
      chk($sformatf("sel d%0d c%0d", k, c), {4'h0, selector},
          (c < 2) ? 8'h0F : {4'h0, es});
      chk($sformatf("sig d%0d c%0d", k, c), signal,
          (c < 2) ? 8'h00 : s);
      chk($sformatf("tick d%0d c%0d", k, c), {7'd0, frame_tick},
          {7'd0, (c == 0) && tk});
      if (ldl && c == 5) load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_assert++;
      assert ($countones(~selector) <= 1) else begin
        n_fail++;
        $error("FAIL onehot: got %b want at most one low", selector);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    value = 16'h0; dp_mask = 4'h0; lz_suppress = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst sel", {4'h0, selector}, 8'h0F);
    chk("rst sig", signal, 8'h00);
    chk("rst pend", {7'd0, pending}, 8'd0);
    chk("rst tick", {7'd0, frame_tick}, 8'd0);

    // preload 1234 while disabled
    rst_n = 1'b1; load = 1'b1; value = 16'h1234;
    @(negedge clk); load = 1'b0;
    chk("pre pend1", {7'd0, pending}, 8'd1);
    @(negedge clk);
    chk("pre pend0", {7'd0, pending}, 8'd0);
    en = 1'b1;

    // frame 1: 1234
    digit(0, 8'h66, 0, 0); digit(1, 8'hF2, 0, 0);
    digit(2, 8'hDA, 0, 0); digit(3, 8'h60, 0, 0);

    // frame 2: load ABCD mid-frame, 1234 still shown
    digit(0, 8'h66, 1, 0);
    chk("f2 pend0", {7'd0, pending}, 8'd0);
    value = 16'hABCD; load = 1'b1;
    digit(1, 8'hF2, 0, 0);
    chk("f2 pend1", {7'd0, pending}, 8'd1);
    digit(2, 8'hDA, 0, 0); digit(3, 8'h60, 0, 0);
    chk("f3 pend0", {7'd0, pending}, 8'd0);

    // frame 3: ABCD, queue 0050 with dp on digit 3
    digit(0, 8'h7A, 1, 0);
    value = 16'h0050; dp_mask = 4'b1000; load = 1'b1;
    digit(1, 8'h1A, 0, 0); digit(2, 8'h3E, 0, 0); digit(3, 8'hEE, 0, 0);

    // frame 4: 0050 with leading-zero suppression
    lz_suppress = 1'b1;
    digit(0, 8'hFC, 1, 0); digit(1, 8'hB6, 0, 0);
    digit(2, 8'h00, 0, 0); digit(3, 8'h01, 0, 0);

    // frame 5: no suppression; load 1111 then 2222 in boundary cycle
    lz_suppress = 1'b0;
    digit(0, 8'hFC, 1, 0);
    value = 16'h1111; dp_mask = 4'h0; load = 1'b1;
    digit(1, 8'hB6, 0, 0);
    value = 16'h2222;
    digit(2, 8'hFC, 0, 0); digit(3, 8'hFD, 0, 1);

    // frame 6: 1111 committed, 2222 still pending
    chk("f6 pend1", {7'd0, pending}, 8'd1);
    digit(0, 8'h60, 1, 0); digit(1, 8'h60, 0, 0);
    digit(2, 8'h60, 0, 0); digit(3, 8'h60, 0, 0);

    // frame 7: 2222, disable while digit 2 is on
    chk("f7 pend0", {7'd0, pending}, 8'd0);
    digit(0, 8'hDA, 1, 0); digit(1, 8'hDA, 0, 0);
    repeat (3) @(negedge clk);
    chk("d2 on sel", {4'h0, selector}, 8'h0B);
    chk("d2 on sig", signal, 8'hDA);
    en = 1'b0;
    @(negedge clk);
    chk("dis sel", {4'h0, selector}, 8'h0F);
    chk("dis sig", signal, 8'h00);
    chk("dis tick", {7'd0, frame_tick}, 8'd0);
    value = 16'h3333; load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("dis pend1", {7'd0, pending}, 8'd1);
    @(negedge clk);
    chk("dis pend0", {7'd0, pending}, 8'd0);
    chk("dis sel2", {4'h0, selector}, 8'h0F);
    en = 1'b1;
    digit(0, 8'hF2, 0, 0);

    // async reset in the middle of digit 1
    repeat (3) @(negedge clk);
    chk("d1 on sel", {4'h0, selector}, 8'h0D);
    chk("d1 on sig", signal, 8'hF2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst sel", {4'h0, selector}, 8'h0F);
    chk("arst sig", signal, 8'h00);
    chk("arst pend", {7'd0, pending}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    digit(0, 8'hFC, 0, 0); digit(1, 8'hFC, 0, 0);
    digit(2, 8'hFC, 0, 0); digit(3, 8'hFC, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
